neuron_accum_ctrl: RTL and testbench
====================================

NEURON_ACCUM_CTRL -- requirements
Module: neuron_accum_ctrl

Interface
REQ-001 SHALL have parameter BIT, default 8, half-width; data word width W = 2*BIT-1 (sign-magnitude, sign at bit W-1).
REQ-002 SHALL have parameter MAX_TERMS, default 784, maximum terms per accumulation; CNT_W = $clog2(MAX_TERMS+1).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin a new accumulation (sampled in IDLE only).
REQ-006 SHALL have port in_valid  input  1  term valid.
REQ-007 SHALL have port in_ready  output  1  term accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  W  sign-magnitude term.
REQ-009 SHALL have port in_last  input  1  marks final term of the accumulation.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_data  output  W  accumulated sum.
REQ-013 SHALL have port out_ovf  output  1  sticky overflow of this accumulation.
REQ-014 SHALL have port out_count  output  CNT_W  number of terms accepted.
REQ-015 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACCUM -> HOLD -> IDLE.
REQ-017 IDLE: in_ready=0, out_valid=0; start=1 -> acc<=0, ovf<=0, count<=0, next ACCUM.
REQ-018 ACCUM: in_ready=1; each accepted term -> acc<=acc+in_data via the sign-magnitude adder, count<=count+1.
REQ-019 Adder overflow (magnitude carry, or either operand = SAT_CODE = {1'b1,{W-1{0}}}) SHALL set ovf and force acc<=SAT_CODE; later terms in the same accumulation are consumed but leave acc unchanged.
REQ-020 Opposite signs with equal magnitude SHALL yield +0 (all zeros), never SAT_CODE.
REQ-021 Accepted term with in_last=1, or accepted term bringing count to MAX_TERMS, SHALL be the final term -> HOLD next cycle.
REQ-022 Latency: out_valid asserts the cycle after the final term is accepted, with out_data, out_ovf, out_count including that term.
REQ-023 HOLD: out_valid=1, in_ready=0, outputs stable until out_valid && out_ready; then IDLE next cycle.
REQ-024 start outside IDLE SHALL be ignored; in_valid in IDLE or HOLD SHALL not be accepted.
REQ-025 start and in_valid in the same IDLE cycle: only start acts; the term is accepted no earlier than the next cycle.
REQ-026 out_data, out_ovf, out_count SHALL be registered; no combinational path from in_data to out_data.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, acc=0, ovf=0, count=0, in_ready=0, out_valid=0, out_data=0, out_ovf=0, out_count=0, busy=0.
REQ-028 Reset mid-ACCUM or mid-HOLD SHALL discard the partial result; no out_valid after release until a new start completes.

Configuration
REQ-029 Macro NEURON_ACCUM_RELU_EN defined: at HOLD entry, a negative non-overflowed result (sign=1, magnitude!=0) SHALL be output as 0; SAT_CODE with out_ovf=1 passes unchanged.
REQ-030 Macro not defined: out_data SHALL be the raw accumulated sum.

Structure
REQ-031 Package neuron_pkg SHALL hold state enum (IDLE, ACCUM, HOLD), and functions for SAT_CODE and sign/magnitude field extraction, all parameterised by W.
REQ-032 SHALL instantiate the existing combinational sign-magnitude adder Float16Adder as its single sub-module; no second adder.

Verification (BIT=8, W=15, SAT_CODE=15'h4000)
REQ-033 start; terms 15'h0003, 15'h0005, 15'h4002(last) -> out_valid one cycle after last, out_data=15'h0006, out_ovf=0, out_count=3.
REQ-034 start; 15'h3FFF, 15'h0001, 15'h0004(last) -> out_data=15'h4000, out_ovf=1, out_count=3.
REQ-035 start; 15'h0002, 15'h4005(last) -> out_data=15'h4003 without macro; 15'h0000 with NEURON_ACCUM_RELU_EN.
REQ-036 Result in HOLD, out_ready low 5 cycles, start pulsed -> out_data stable, in_ready=0, start ignored; out_ready high -> IDLE next cycle.
REQ-037 rst_n low after 2 terms in ACCUM -> all outputs 0 immediately; new start plus 15'h0007(last) -> out_data=15'h0007, out_count=1.
REQ-038 MAX_TERMS=4, five terms 15'h0001 without in_last -> HOLD after 4th, out_data=15'h0004, out_count=4, 5th term not accepted.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and sign-magnitude helpers for the neuron accumulator.
// Helpers take the word width as an argument and work on a 64-bit
// container so every user can stay parameterised on its own W.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Saturation code: sign set, magnitude zero ("negative zero").
  function automatic logic [63:0] sat_code(input int w);
    sat_code = 64'd1 << (w - 1);
  endfunction

  // Sign bit of a w-bit sign-magnitude word.
  function automatic logic sign_of(input logic [63:0] v, input int w);
    logic [63:0] t;
    t = v >> (w - 1);
    sign_of = t[0];
  endfunction

  // Magnitude field of a w-bit sign-magnitude word.
  function automatic logic [63:0] mag_of(input logic [63:0] v, input int w);
    mag_of = v & ((64'd1 << (w - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/neuron_accum_ctrl_adder.sv
// Combinational sign-magnitude adder (Float16Adder).
// Overflow on magnitude carry or when either operand is the saturation code;
// equal magnitudes of opposite sign give +0.
module Float16Adder
  import neuron_pkg::*;
#(
  parameter int W = 15
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam int M = W - 1;

  logic [W-1:0] sat_s;
  logic         sa_s;
  logic         sb_s;
  logic [M-1:0] ma_s;
  logic [M-1:0] mb_s;
  logic [M:0]   msum_s;

  assign sat_s  = W'(sat_code(W));
  assign sa_s   = sign_of(64'(a), W);
  assign sb_s   = sign_of(64'(b), W);
  assign ma_s   = M'(mag_of(64'(a), W));
  assign mb_s   = M'(mag_of(64'(b), W));
  assign msum_s = {1'b0, ma_s} + {1'b0, mb_s};

  // Add or subtract magnitudes depending on signs, saturating on overflow.
  always_comb begin
    sum = {W{1'b0}};
    ovf = 1'b0;
    if ((a == sat_s) || (b == sat_s)) begin
      sum = sat_s;
      ovf = 1'b1;
    end else if (sa_s == sb_s) begin
      if (msum_s[M]) begin
        sum = sat_s;
        ovf = 1'b1;
      end else begin
        sum = {sa_s, msum_s[M-1:0]};
      end
    end else if (ma_s > mb_s) begin
      sum = {sa_s, ma_s - mb_s};
    end else if (mb_s > ma_s) begin
      sum = {sb_s, mb_s - ma_s};
    end else begin
      sum = {W{1'b0}};
    end
  end

endmodule

// File: rtl/neuron_accum_ctrl.sv
// Neuron accumulation controller: accepts a stream of sign-magnitude terms,
// sums them through a single Float16Adder, and holds the result until taken.
// Optional feature macro: NEURON_ACCUM_RELU_EN (clamp negative results to 0).
module neuron_accum_ctrl
  import neuron_pkg::*;
#(
  parameter  int BIT       = 8,
  parameter  int MAX_TERMS = 784,
  localparam int W         = 2 * BIT - 1,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int M = W - 1;

  state_t           state_r;
  state_t           state_next_s;
  logic [W-1:0]     acc_r;
  logic             ovf_r;
  logic [CNT_W-1:0] count_r;

  logic [W-1:0]     add_sum_s;
  logic             add_ovf_s;
  logic             accept_s;
  logic             final_s;
  logic [CNT_W-1:0] count_inc_s;
  logic [W-1:0]     acc_next_s;
  logic             ovf_next_s;
  logic [W-1:0]     result_s;
  logic [W-1:0]     sat_s;

  assign sat_s = W'(sat_code(W));

  Float16Adder #(.W(W)) u_adder (
    .a   (acc_r),
    .b   (in_data),
    .sum (add_sum_s),
    .ovf (add_ovf_s)
  );

  // Term handshake, running count and final-term detection.
  always_comb begin
    accept_s    = (state_r == ACCUM) && in_valid;
    count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    final_s     = accept_s && (in_last || (count_inc_s == CNT_W'(MAX_TERMS)));
  end

  // Next accumulator value; once saturated, later terms leave it alone.
  always_comb begin
    acc_next_s = acc_r;
    ovf_next_s = ovf_r;
    if (ovf_r) begin
      acc_next_s = acc_r;
      ovf_next_s = 1'b1;
    end else if (add_ovf_s) begin
      acc_next_s = sat_s;
      ovf_next_s = 1'b1;
    end else begin
      acc_next_s = add_sum_s;
      ovf_next_s = 1'b0;
    end
  end

  // Value presented on out_data at HOLD entry.
  always_comb begin
    result_s = acc_next_s;
`ifdef NEURON_ACCUM_RELU_EN
    if (!ovf_next_s && acc_next_s[W-1] && (acc_next_s[M-1:0] != {M{1'b0}})) begin
      result_s = {W{1'b0}};
    end else begin
      result_s = acc_next_s;
    end
`else
    result_s = acc_next_s;
`endif
  end

  // Next-state logic of the IDLE -> ACCUM -> HOLD -> IDLE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = ACCUM;
        else       state_next_s = IDLE;
      end
      ACCUM: begin
        if (final_s) state_next_s = HOLD;
        else         state_next_s = ACCUM;
      end
      HOLD: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = HOLD;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus registered status outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      in_ready  <= (state_next_s == ACCUM);
      out_valid <= (state_next_s == HOLD);
      busy      <= (state_next_s != IDLE);
    end
  end

  // Working accumulator, sticky overflow and term count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {W{1'b0}};
      ovf_r   <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      acc_r   <= {W{1'b0}};
      ovf_r   <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      acc_r   <= acc_next_s;
      ovf_r   <= ovf_next_s;
      count_r <= count_inc_s;
    end else begin
      acc_r   <= acc_r;
      ovf_r   <= ovf_r;
      count_r <= count_r;
    end
  end

  // Result registers, captured with the final term and held through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= {W{1'b0}};
      out_ovf   <= 1'b0;
      out_count <= {CNT_W{1'b0}};
    end else if (final_s) begin
      out_data  <= result_s;
      out_ovf   <= ovf_next_s;
      out_count <= count_inc_s;
    end else begin
      out_data  <= out_data;
      out_ovf   <= out_ovf;
      out_count <= out_count;
    end
  end

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// Self-checking bench for neuron_accum_ctrl (BIT=8, MAX_TERMS=4).
// Honours NEURON_ACCUM_RELU_EN in its expectations.
module tb_neuron_accum_ctrl;

  localparam int BIT   = 8;
  localparam int MT    = 4;
  localparam int W     = 2 * BIT - 1;
  localparam int CNT_W = $clog2(MT + 1);
  localparam int MAXMAG = (1 << (W - 1)) - 1;
  localparam logic [W-1:0] SAT = 15'h4000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  neuron_accum_ctrl #(.BIT(BIT), .MAX_TERMS(MT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int sm2int(input logic [W-1:0] v);
    int mag;
    mag = int'(v[W-2:0]);
    return v[W-1] ? -mag : mag;
  endfunction

  function automatic logic [W-1:0] enc(input int s, input bit ovf);
    logic [W-1:0] r;
    if (ovf) r = SAT;
    else if (s < 0) begin
`ifdef NEURON_ACCUM_RELU_EN
      r = '0;
`else
      r = {1'b1, 14'(-s)};
`endif
    end else r = W'(s);
    return r;
  endfunction

  int   m_phase = 0;   // 0 waiting for start, 1 collecting, 2 result pending
  int   m_sum   = 0;
  bit   m_ovf   = 0;
  int   m_cnt   = 0;
  logic [W-1:0] e_data = '0;
  bit   e_ovf = 0;
  int   e_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_sum = 0; m_ovf = 0; m_cnt = 0;
      e_data = '0; e_ovf = 0; e_cnt = 0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_sum = 0; m_ovf = 0; m_cnt = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (in_valid) begin
          if (in_data == SAT) m_ovf = 1;
          if (!m_ovf) begin
            m_sum = m_sum + sm2int(in_data);
            if (m_sum > MAXMAG || m_sum < -MAXMAG) m_ovf = 1;
          end
          m_cnt++;
          if (in_last || m_cnt == MT) begin
            e_data = enc(m_sum, m_ovf);
            e_ovf = m_ovf;
            e_cnt = m_cnt;
            m_phase = 2;
          end
        end
      end else begin
        if (out_ready) m_phase = 0;
      end
    end
  end

  // Compare process: every falling edge, status always, result while valid.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_phase == 1));
    check("out_valid", 32'(out_valid), 32'(m_phase == 2));
    check("busy", 32'(busy), 32'(m_phase != 0));
    if (m_phase == 2) begin
      check("out_data", 32'(out_data), 32'(e_data));
      check("out_ovf", 32'(out_ovf), 32'(e_ovf));
      check("out_count", 32'(out_count), 32'(e_cnt));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic start_acc();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic put(input logic [W-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_take", 32'(busy), 32'd0);
  endtask

  logic [W-1:0] held;

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed-sign sum
    start_acc();
    put(15'h0003, 1'b0);
    put(15'h0005, 1'b0);
    put(15'h4002, 1'b1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h0006);
    check("t1_ovf", 32'(out_ovf), 32'd0);
    check("t1_count", 32'(out_count), 32'd3);
    drain();

    // Overflow saturates and sticks
    start_acc();
    put(15'h3FFF, 1'b0);
    put(15'h0001, 1'b0);
    put(15'h0004, 1'b1);
    check("t2_data", 32'(out_data), 32'h4000);
    check("t2_ovf", 32'(out_ovf), 32'd1);
    check("t2_count", 32'(out_count), 32'd3);
    drain();

    // Negative result, optionally clamped
    start_acc();
    put(15'h0002, 1'b0);
    put(15'h4005, 1'b1);
`ifdef NEURON_ACCUM_RELU_EN
    check("t3_data", 32'(out_data), 32'h0000);
`else
    check("t3_data", 32'(out_data), 32'h4003);
`endif
    // Hold with out_ready low, start and in_valid ignored
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      in_valid = 1'b1;
      in_data = 15'h0011;
      @(negedge clk);
      check("t4_stable", 32'(out_data), 32'(held));
      check("t4_in_ready", 32'(in_ready), 32'd0);
      check("t4_valid", 32'(out_valid), 32'd1);
    end
    start = 1'b0; in_valid = 1'b0;
    drain();

    // Equal magnitudes, opposite signs -> +0
    start_acc();
    put(15'h0009, 1'b0);
    put(15'h4009, 1'b1);
    check("t5_zero", 32'(out_data), 32'h0000);
    check("t5_ovf", 32'(out_ovf), 32'd0);
    drain();

    // Asynchronous reset mid-accumulation
    start_acc();
    put(15'h0001, 1'b0);
    put(15'h0002, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_valid", 32'(out_valid), 32'd0);
    start_acc();
    put(15'h0007, 1'b1);
    check("t6_data", 32'(out_data), 32'h0007);
    check("t6_count", 32'(out_count), 32'd1);
    drain();

    // Term-count limit ends the accumulation
    start_acc();
    for (int i = 0; i < 5; i++) put(15'h0001, 1'b0);
    check("t7_valid", 32'(out_valid), 32'd1);
    check("t7_data", 32'(out_data), 32'h0004);
    check("t7_count", 32'(out_count), 32'd4);
    drain();

    // start and in_valid together in IDLE: only start acts
    start = 1'b1; in_valid = 1'b1; in_data = 15'h0005; in_last = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t8_not_taken", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("t8_data", 32'(out_data), 32'h0005);
    check("t8_count", 32'(out_count), 32'd1);
    drain();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      start     = ($urandom_range(0, 4) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      in_data = SAT;
      else if (r < 6)  in_data = {1'($urandom_range(0, 1)), 14'($urandom_range(0, 15))};
      else             in_data = 15'($urandom);
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
